// File: rtl/issue_buffer.sv
// Circular instruction buffer between fetch and decode: accepts up to FETCH_W
// instructions per cycle and issues an in-order, hazard-free group of up to ISSUE_W.
module issue_buffer #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned FETCH_W = 2,
    parameter int unsigned ISSUE_W = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [FETCH_W-1:0]           in_valid,
    input  logic [32*FETCH_W-1:0]        in_instr,
    input  logic [32*FETCH_W-1:0]        in_pcplus4,
    output logic                         in_ready,
    output logic [ISSUE_W-1:0]           out_valid,
    output logic [32*ISSUE_W-1:0]        out_instr,
    output logic [32*ISSUE_W-1:0]        out_pcplus4,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc_q    [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    logic [31:0]   g_instr [ISSUE_W];
    logic [31:0]   g_pc    [ISSUE_W];
    logic [ISSUE_W-1:0] grp_valid;
    logic          enq;
    logic [CW-1:0] n_enq;
    logic [CW-1:0] n_deq;

    // Architectural destination register; 0 means the instruction writes nothing.
    function automatic logic [4:0] dest_of(input logic [31:0] w);
        logic [5:0] op;
        op = w[31:26];
        dest_of = 5'd0;
        case (op)
            6'h00: dest_of = (w[5:0] == 6'h08) ? 5'd0 : w[15:11];
            6'h23, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0F: dest_of = w[20:16];
            6'h03: dest_of = 5'd31;
            default: dest_of = 5'd0;
        endcase
    endfunction

    function automatic logic is_mem(input logic [31:0] w);
        is_mem = (w[31:26] == 6'h23) || (w[31:26] == 6'h2B);
    endfunction

    function automatic logic is_ctrl(input logic [31:0] w);
        logic [5:0] op;
        op = w[31:26];
        is_ctrl = (op == 6'h04) || (op == 6'h05) || (op == 6'h02) || (op == 6'h03) ||
                  ((op == 6'h00) && (w[5:0] == 6'h08));
    endfunction

    // rs and rt are both treated as reads; $0 never creates a dependency.
    function automatic logic reads_reg(input logic [31:0] w, input logic [4:0] r);
        reads_reg = (r != 5'd0) && ((w[25:21] == r) || (w[20:16] == r));
    endfunction

    // Group formation over the head entries.
    always_comb begin
        logic ok;
        grp_valid = '0;
        for (int k = 0; k < int'(ISSUE_W); k++) begin
            g_instr[k] = instr_q[head + PW'(k)];
            g_pc[k]    = pc_q[head + PW'(k)];
        end
        grp_valid[0] = (count != '0) && !flush;
        for (int k = 1; k < int'(ISSUE_W); k++) begin
            ok = grp_valid[k-1] && (int'(count) > k) && !is_ctrl(g_instr[k-1]);
            for (int j = 0; j < k; j++) begin
                if (reads_reg(g_instr[k], dest_of(g_instr[j])))
                    ok = 1'b0;
                if ((dest_of(g_instr[k]) != 5'd0) && (dest_of(g_instr[k]) == dest_of(g_instr[j])))
                    ok = 1'b0;
                if (is_mem(g_instr[k]) && is_mem(g_instr[j]))
                    ok = 1'b0;
            end
            grp_valid[k] = ok;
        end
    end

    always_comb begin
        out_valid   = grp_valid;
        out_instr   = '0;
        out_pcplus4 = '0;
        for (int k = 0; k < int'(ISSUE_W); k++) begin
            if (grp_valid[k]) begin
                out_instr[32*k +: 32]   = g_instr[k];
                out_pcplus4[32*k +: 32] = g_pc[k];
            end
        end
    end

    // Space check uses the start-of-cycle count only, so out_ready never reaches in_ready.
    assign in_ready = !reset && !flush && ((32'(count) + 32'(FETCH_W)) <= 32'(DEPTH));
    assign enq      = in_ready && in_valid[0];
    assign n_enq    = enq ? CW'($countones(in_valid)) : '0;
    assign n_deq    = out_ready ? CW'($countones(grp_valid)) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + PW'(n_enq);
            head  <= head + PW'(n_deq);
            count <= count + n_enq - n_deq;
        end
    end

    // Storage carries no reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(FETCH_W); k++) begin
            if (enq && in_valid[k]) begin
                instr_q[tail + PW'(k)] <= in_instr[32*k +: 32];
                pc_q[tail + PW'(k)]    <= in_pcplus4[32*k +: 32];
            end
        end
    end

endmodule

// File: tb/tb_issue_buffer.sv
// Directed self-checking bench for issue_buffer (DEPTH=8, FETCH_W=2, ISSUE_W=2).
module tb_issue_buffer;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned FETCH_W = 2;
    localparam int unsigned ISSUE_W = 2;
    localparam int unsigned CW      = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic [1:0]    in_valid;
    logic [63:0]   in_instr;
    logic [63:0]   in_pcplus4;
    logic          in_ready;
    logic [1:0]    out_valid;
    logic [63:0]   out_instr;
    logic [63:0]   out_pcplus4;
    logic          out_ready;
    logic [CW-1:0] count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] q[$];
    logic [1:0]  v;
    logic [1:0]  ev;
    logic        rdy_exp;
    int          sent;
    int          cyc;
    int          m;
    int          n;
    int          r;

    issue_buffer #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_pcplus4(in_pcplus4),
        .in_ready(in_ready), .out_valid(out_valid), .out_instr(out_instr),
        .out_pcplus4(out_pcplus4), .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int funct);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(funct)};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    // Mutually independent addu stream: reads $1/$2, writes $3..$22.
    function automatic logic [31:0] gen(input int i);
        return rtype(1, 2, 3 + (i % 20), 'h21);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] vv, input logic [31:0] a, input logic [31:0] b);
        in_valid   = vv;
        in_instr   = {b, a};
        in_pcplus4 = {32'h0000_1008, 32'h0000_1004};
        tick();
        in_valid   = 2'b00;
    endtask

    task automatic drain1();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic drain_all(input string tag);
        out_ready = 1'b1;
        for (int c = 0; c < 10 && count != '0; c++) tick();
        out_ready = 1'b0;
        chk(tag, 32'(count), 0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 2'b00; in_instr = '0;
        in_pcplus4 = '0; out_ready = 1'b0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_out_instr", out_instr[31:0], 0);
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);

        // Two independent R-types issue together
        push(2'b11, rtype(1, 2, 3, 'h21), rtype(4, 5, 6, 'h25));
        chk("pair_count", 32'(count), 2);
        chk("pair_valid", 32'(out_valid), 32'b11);
        chk("pair_slot0", out_instr[31:0], rtype(1, 2, 3, 'h21));
        chk("pair_slot1", out_instr[63:32], rtype(4, 5, 6, 'h25));
        chk("pair_pc1", out_pcplus4[63:32], 32'h0000_1008);
        drain1();
        chk("pair_drained", 32'(count), 0);
        chk("pair_drained_valid", 32'(out_valid), 0);
        chk("pair_drained_instr", out_instr[31:0], 0);

        // RAW splits the group
        push(2'b11, rtype(1, 2, 3, 'h21), rtype(3, 5, 4, 'h23));
        chk("raw_valid", 32'(out_valid), 32'b01);
        chk("raw_slot1_zero", out_instr[63:32], 0);
        drain1();
        chk("raw_second_valid", 32'(out_valid), 32'b01);
        chk("raw_second_instr", out_instr[31:0], rtype(3, 5, 4, 'h23));
        drain1();
        push(2'b11, rtype(1, 2, 0, 'h21), rtype(0, 5, 4, 'h23));
        chk("raw_r0_valid", 32'(out_valid), 32'b11);
        drain1();

        // Single memory port
        push(2'b11, itype('h23, 1, 2, 0), itype('h2B, 1, 3, 4));
        chk("mem_valid", 32'(out_valid), 32'b01);
        drain1();
        chk("mem_second_valid", 32'(out_valid), 32'b01);
        chk("mem_second_instr", out_instr[31:0], itype('h2B, 1, 3, 4));
        drain1();
        push(2'b11, itype('h23, 1, 2, 0), rtype(6, 7, 5, 'h21));
        chk("lw_alu_valid", 32'(out_valid), 32'b11);
        drain1();

        // Control flow ends the group
        push(2'b11, itype('h04, 1, 2, 3), rtype(6, 7, 5, 'h21));
        chk("beq_valid", 32'(out_valid), 32'b01);
        drain_all("beq_drained");

        // Fill to full, overflow push dropped
        for (int i = 0; i < 4; i++) push(2'b11, gen(2*i), gen(2*i+1));
        chk("full_count", 32'(count), 8);
        chk("full_in_ready", 32'(in_ready), 0);
        push(2'b11, gen(8), gen(9));
        chk("full_dropped_count", 32'(count), 8);
        chk("full_head", out_instr[31:0], gen(0));
        drain1();
        chk("six_count", 32'(count), 6);
        out_ready = 1'b1;
        push(2'b11, gen(8), gen(9));
        out_ready = 1'b0;
        chk("simul_count", 32'(count), 6);
        drain_all("full_drained");

        // Random-ish stream across wrap-around against a queue model
        sent = 0; cyc = 0;
        while ((sent < 40 || q.size() != 0) && cyc < 400) begin
            if (sent < 40) begin
                r = $urandom_range(0, 2);
                v = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
                if (sent == 39 && v == 2'b11) v = 2'b01;
            end else begin
                v = 2'b00;
            end
            in_valid  = v;
            in_instr  = {gen(sent + 1), gen(sent)};
            out_ready = 1'($urandom_range(0, 1));
            #3;
            rdy_exp = (q.size() + 2) <= 8;
            ev = (q.size() >= 2) ? 2'b11 : (q.size() == 1) ? 2'b01 : 2'b00;
            chk("wrap_count", 32'(count), q.size());
            chk("wrap_in_ready", 32'(in_ready), 32'(rdy_exp));
            chk("wrap_out_valid", 32'(out_valid), 32'(ev));
            m = 0;
            if (out_ready) begin
                for (int k = 0; k < 2; k++) begin
                    if (ev[k]) begin
                        chk("wrap_order", out_instr[32*k +: 32], q[k]);
                        m++;
                    end
                end
            end
            repeat (m) void'(q.pop_front());
            n = 0;
            if (rdy_exp && v[0]) begin
                n = v[1] ? 2 : 1;
                for (int k = 0; k < n; k++) q.push_back(gen(sent + k));
            end
            sent += n;
            tick();
            cyc++;
        end
        in_valid = 2'b00; out_ready = 1'b0;
        chk("wrap_sent", 32'(sent), 40);
        chk("wrap_empty", 32'(count), 0);

        // Flush at count 5 overrides in_valid and out_ready
        push(2'b11, gen(0), gen(1));
        push(2'b11, gen(2), gen(3));
        push(2'b01, gen(4), gen(5));
        chk("pre_flush_count", 32'(count), 5);
        flush = 1'b1; in_valid = 2'b11; out_ready = 1'b1;
        #2;
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_in_ready", 32'(in_ready), 0);
        chk("flush_out_instr", out_instr[31:0], 0);
        tick();
        flush = 1'b0; in_valid = 2'b00; out_ready = 1'b0;
        #1;
        chk("post_flush_count", 32'(count), 0);
        chk("post_flush_valid", 32'(out_valid), 0);
        chk("post_flush_in_ready", 32'(in_ready), 1);

        // Asynchronous reset mid-stream
        push(2'b11, gen(0), gen(1));
        chk("pre_reset_valid", 32'(out_valid), 32'b11);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_count", 32'(count), 0);
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_in_ready", 32'(in_ready), 0);
        tick();
        reset = 1'b0;
        #1;
        chk("rerst_in_ready", 32'(in_ready), 1);
        chk("rerst_count", 32'(count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
